srl_sra_multicycle: RTL and testbench
=====================================

Name: srl_sra_multicycle

Overview:
Iterative 32-bit right shifter: logical (srl) or arithmetic (sra), selected per operation. It is the right-shift counterpart of the combinational left shifter in the ALU. It resolves one shamt bit per clock (stages 16, 8, 4, 2, 1) and uses a start/busy/resultReady handshake. It sits beside the ALU datapath for multicycle shift instructions and trades latency for a single 32-bit 2:1 mux stage.

Parameters:
none (data width fixed at 32, shamt fixed at 5 bits)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 forces reset state immediately
start  input  1  request; sampled on rising edge when the unit is not busy
operandA  input  32  value to shift; sampled with start
shamt  input  5  shift amount 0..31; sampled with start
arith  input  1  1 = arithmetic (fill with operandA[31]), 0 = logical (fill with 0); sampled with start
shiftedNum  output  32  registered result; holds last completed result
busy  output  1  1 while an operation is in progress
resultReady  output  1  one-cycle pulse when shiftedNum carries a new result

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, shiftedNum=0, busy=0, resultReady=0, stage counter=0, internal latches=0.
- States:
  - IDLE: busy=0, resultReady=0.
  - SHIFT: busy=1, 5 cycles, counter 0..4.
  - DONE: busy=0, resultReady=1, exactly 1 cycle.
- Acceptance: start=1 at a rising edge in IDLE or DONE:
  - latch operandA into the work register, and latch shamt and arith;
  - latch the fill bit: operandA[31] if arith=1, else 0;
  - counter=0; go to SHIFT.
- start=1 in SHIFT is ignored; latched operands are unaffected.
- SHIFT, counter c (0..4), selected amount k = 16>>c, controlling bit = latched shamt[4-c]:
  - if that bit is 1: work = {k copies of fill, work[31:k]};
  - else work unchanged.
- c=4 edge: shiftedNum <= final work value, next state DONE. Otherwise counter increments.
- DONE with no start: next state IDLE. DONE with start: new operation accepted, next state SHIFT.
- Latency: start sampled at edge T; shiftedNum updates and resultReady rises at edge T+5; resultReady falls at edge T+6. Fixed latency, including shamt=0.
- shiftedNum changes only at the completing edge (or reset). It is stable in IDLE, SHIFT, and DONE otherwise.
- Fill bit is captured from the original operandA[31], never recomputed from work.
- Arithmetic result equals floor(signed operandA / 2^shamt). Logical result equals unsigned operandA >> shamt.
- Reset asserted mid-SHIFT aborts the operation: no resultReady, shiftedNum=0.
- Input changes after the accepting edge have no effect on the operation in flight.

Test Plan:
- arith=0, operandA=0x80000000, shamt=31, start at T → shiftedNum=0x00000001 at T+5, resultReady high exactly one cycle, busy high T+1..T+5 edges.
- arith=1, operandA=0x80000000, shamt=4 → 0xF8000000; arith=1, operandA=0x7FFFFFF0, shamt=4 → 0x07FFFFFF.
- arith=1, operandA=0xDEADBEEF, shamt=0 → 0xDEADBEEF after the full 5-cycle latency; arith=1, operandA=0xFFFFFFFF, shamt=31 → 0xFFFFFFFF.
- start asserted with new operands (0x12345678, shamt=8) during SHIFT → ignored; original result delivered. Start in the DONE cycle (operandA=0x00000100, shamt=8, arith=0) → accepted, 0x00000001 five edges later, no IDLE gap.
- reset driven low two cycles after start (operandA=0xFFFF0000, shamt=16, arith=1) → immediately shiftedNum=0, busy=0, resultReady=0. After release, no pulse until a new start; a new start runs normally.
- Random sweep of 1000 operands, shamt 0..31, both arith values → matches reference model (>> and >>>), exactly one resultReady per accepted start.

Source files
------------

// File: rtl/srl_sra_multicycle_if.sv
// Handshake and data bundle for the multicycle right shifter.
// The master issues operations; the slave (the shifter) returns results.
interface srl_sra_multicycle_if;
    logic        start;
    logic [31:0] operandA;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] shiftedNum;
    logic        busy;
    logic        resultReady;

    modport master (
        output start, operandA, shamt, arith,
        input  shiftedNum, busy, resultReady
    );

    modport slave (
        input  start, operandA, shamt, arith,
        output shiftedNum, busy, resultReady
    );
endinterface

// File: rtl/srl_sra_multicycle.sv
// Iterative 32-bit logical/arithmetic right shifter: one shamt bit per clock,
// stages 16, 8, 4, 2, 1, with a start/busy/resultReady handshake.
module srl_sra_multicycle (
    input logic                  i_clock,
    input logic                  i_reset,  // asynchronous, active-low
    srl_sra_multicycle_if.slave  io_bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_work;
    logic [31:0] r_result;
    logic [4:0]  r_shamt;
    logic        r_fill;
    logic [2:0]  r_cnt;
    logic        w_accept;
    logic        w_bit;
    logic [31:0] w_stage;
    logic [31:0] w_work_next;
    logic        w_busy;
    logic        w_ready;

    assign w_accept = io_bus.start && (r_state != StShift);

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (io_bus.start) w_state_next = StShift;
            StShift: if (r_cnt == 3'd4) w_state_next = StDone;
            StDone:  w_state_next = io_bus.start ? StShift : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy  = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            StShift: w_busy  = 1'b1;
            StDone:  w_ready = 1'b1;
            default: ;
        endcase
    end

    // Stage c shifts by 16>>c under control of shamt[4-c]
    always_comb begin
        w_bit   = 1'b0;
        w_stage = r_work;
        case (r_cnt)
            3'd0: begin w_bit = r_shamt[4]; w_stage = {{16{r_fill}}, r_work[31:16]}; end
            3'd1: begin w_bit = r_shamt[3]; w_stage = {{8{r_fill}}, r_work[31:8]};   end
            3'd2: begin w_bit = r_shamt[2]; w_stage = {{4{r_fill}}, r_work[31:4]};   end
            3'd3: begin w_bit = r_shamt[1]; w_stage = {{2{r_fill}}, r_work[31:2]};   end
            3'd4: begin w_bit = r_shamt[0]; w_stage = {r_fill, r_work[31:1]};        end
            default: ;
        endcase
        w_work_next = w_bit ? w_stage : r_work;
    end

    // Fill bit is captured once from the original operand, never from work
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_work   <= '0;
            r_result <= '0;
            r_shamt  <= '0;
            r_fill   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_work  <= io_bus.operandA;
            r_shamt <= io_bus.shamt;
            r_fill  <= io_bus.arith & io_bus.operandA[31];
            r_cnt   <= '0;
        end else if (r_state == StShift) begin
            r_work <= w_work_next;
            if (r_cnt == 3'd4) begin
                r_result <= w_work_next;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign io_bus.shiftedNum  = r_result;
    assign io_bus.busy        = w_busy;
    assign io_bus.resultReady = w_ready;

endmodule

// File: tb/tb_srl_sra_multicycle.sv
// Directed and swept checks of the multicycle right shifter against
// hand-computed values and a shift-operator reference.
module tb_srl_sra_multicycle;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    srl_sra_multicycle_if bus ();

    srl_sra_multicycle dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic start_op(input logic [31:0] a, input logic [4:0] sh, input logic ar);
        bus.start    = 1'b1;
        bus.operandA = a;
        bus.shamt    = sh;
        bus.arith    = ar;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.operandA = 32'hA5A5_5A5A;
        bus.shamt    = ~sh;
        bus.arith    = ~ar;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic ar,
                          input logic [31:0] exp, input string tag);
        logic [31:0] prev;
        prev = bus.shiftedNum;
        start_op(a, sh, ar);
        check({tag, "_busy0"}, {31'b0, bus.busy}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
            check({tag, "_rdy_early"}, {31'b0, bus.resultReady}, 32'd0);
            check({tag, "_hold"}, bus.shiftedNum, prev);
        end
        @(negedge clk);
        check({tag, "_rdy"}, {31'b0, bus.resultReady}, 32'd1);
        check({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_res"}, bus.shiftedNum, exp);
        @(negedge clk);
        check({tag, "_rdy_fall"}, {31'b0, bus.resultReady}, 32'd0);
        check({tag, "_res_hold"}, bus.shiftedNum, exp);
    endtask

    initial begin
        logic [31:0]        a;
        logic signed [31:0] sa;
        logic [4:0]         sh;
        logic               ar;
        logic [31:0]        exp;
        int                 pulses;

        n_checks     = 0;
        n_fail       = 0;
        bus.start    = 1'b0;
        bus.operandA = '0;
        bus.shamt    = '0;
        bus.arith    = 1'b0;
        rst_n        = 1'b0;
        #3;
        check("rst_res", bus.shiftedNum, 32'h0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_rdy", {31'b0, bus.resultReady}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, "srl31");
        run_op(32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, "sra4_neg");
        run_op(32'h7FFF_FFF0, 5'd4,  1'b1, 32'h07FF_FFFF, "sra4_pos");
        run_op(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, "sra0");
        run_op(32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, "sra31");
        run_op(32'hF000_0000, 5'd4,  1'b0, 32'h0F00_0000, "srl4");

        // start during SHIFT is ignored
        start_op(32'h8000_0000, 5'd8, 1'b1);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.operandA = 32'h1234_5678;
        bus.shamt    = 5'd8;
        bus.arith    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_busy", {31'b0, bus.busy}, 32'd1);
        repeat (2) @(negedge clk);
        check("ign_rdy_early", {31'b0, bus.resultReady}, 32'd0);
        @(negedge clk);
        check("ign_rdy", {31'b0, bus.resultReady}, 32'd1);
        check("ign_res", bus.shiftedNum, 32'hFF80_0000);
        @(negedge clk);
        check("ign_rdy_fall", {31'b0, bus.resultReady}, 32'd0);
        check("ign_idle", {31'b0, bus.busy}, 32'd0);

        // start in the DONE cycle chains without an IDLE gap
        start_op(32'h0000_FF00, 5'd8, 1'b0);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("chain1_rdy", {31'b0, bus.resultReady}, 32'd1);
        check("chain1_res", bus.shiftedNum, 32'h0000_00FF);
        start_op(32'h0000_0100, 5'd8, 1'b0);
        check("chain2_busy0", {31'b0, bus.busy}, 32'd1);
        check("chain2_rdy0", {31'b0, bus.resultReady}, 32'd0);
        repeat (4) @(negedge clk);
        check("chain2_hold", bus.shiftedNum, 32'h0000_00FF);
        @(negedge clk);
        check("chain2_rdy", {31'b0, bus.resultReady}, 32'd1);
        check("chain2_res", bus.shiftedNum, 32'h0000_0001);
        @(negedge clk);

        // reset mid-SHIFT aborts
        start_op(32'hFFFF_0000, 5'd16, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_res", bus.shiftedNum, 32'h0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_rdy", {31'b0, bus.resultReady}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.resultReady) pulses++;
        end
        check("abort_no_pulse", pulses, 32'd0);
        run_op(32'hFFFF_0000, 5'd16, 1'b1, 32'hFFFF_FFFF, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            a  = $urandom;
            sh = 5'($urandom_range(0, 31));
            ar = 1'($urandom_range(0, 1));
            sa = a;
            exp = ar ? 32'(sa >>> sh) : (a >> sh);
            run_op(a, sh, ar, exp, "sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
